// File: rtl/modcnt_n.sv
// Modulo-(limit+1) up/down counter with load, step-by-1/2 and a registered wrap flag.
// Optional saturate mode is compiled in when MODCNT_SAT_EN is defined (adds port sat).
module modcnt_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             step,
    input  logic             down,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] limit,
`ifdef MODCNT_SAT_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] q,
    output logic             wrap
);

    localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;

    logic             w_sat;
    logic [WIDTH:0]   w_q_ext;
    logic [WIDTH:0]   w_lim_ext;
    logic [WIDTH:0]   w_mod;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_up_wrap;
    logic [WIDTH:0]   w_dn_wrap;
    logic [WIDTH:0]   w_dn_sub;
    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap_next;
    logic             w_unused;

`ifdef MODCNT_SAT_EN
    assign w_sat = sat;
`else
    assign w_sat = 1'b0;
`endif

    // One extra bit so limit = 2^WIDTH-1 gives a modulus of 2^WIDTH without overflow.
    assign w_q_ext   = {1'b0, r_q};
    assign w_lim_ext = {1'b0, limit};
    assign w_mod     = w_lim_ext + ONE;
    assign w_inc     = {{(WIDTH-1){1'b0}}, step, ~step};
    assign w_sum     = w_q_ext + w_inc;
    assign w_up_wrap = w_sum - w_mod;
    assign w_dn_sub  = w_q_ext - w_inc;
    assign w_dn_wrap = w_mod - (w_inc - w_q_ext);
    assign w_unused  = ^{w_up_wrap[WIDTH], w_dn_wrap[WIDTH], w_dn_sub[WIDTH]};

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        w_q_next    = r_q;
        w_wrap_next = 1'b0;
        if (load) begin
            w_q_next = d;
        end else if (en) begin
            w_wrap_next = 1'b1;
            if (w_q_ext > w_lim_ext) begin
                w_q_next = down ? limit : '0;
            end else if (limit == '0) begin
                // Modulus 1: the step-by-2 wrap formula would leave range, so pin to 0.
                w_q_next = '0;
            end else if (!down) begin
                if (w_sum <= w_lim_ext) begin
                    w_q_next    = w_sum[WIDTH-1:0];
                    w_wrap_next = 1'b0;
                end else begin
                    w_q_next = w_sat ? limit : w_up_wrap[WIDTH-1:0];
                end
            end else begin
                if (w_q_ext >= w_inc) begin
                    w_q_next    = w_dn_sub[WIDTH-1:0];
                    w_wrap_next = 1'b0;
                end else begin
                    w_q_next = w_sat ? '0 : w_dn_wrap[WIDTH-1:0];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset is asynchronous active-low.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign q    = r_q;
    assign wrap = r_wrap;

endmodule

// File: doc/modcnt_n.md
MODCNT_N -- requirements
Module: modcnt_n

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port nrst, input, 1: reset, asynchronous, active-low.
REQ-004 Port en, input, 1: count enable.
REQ-005 Port step, input, 1: increment select; 0 = count by 1, 1 = count by 2.
REQ-006 Port down, input, 1: direction; 0 = up, 1 = down.
REQ-007 Port load, input, 1: synchronous load strobe.
REQ-008 Port d, input, WIDTH: load value.
REQ-009 Port limit, input, WIDTH: modulus minus one; count range is 0..limit inclusive.
REQ-010 Port sat, input, 1: saturate-mode select; present only when MODCNT_SAT_EN is defined.
REQ-011 Port q, output, WIDTH: registered count value.
REQ-012 Port wrap, output, 1: registered event flag, defined in REQ-019..REQ-021.

Function
REQ-013 The increment inc SHALL be 1 when step=0 and 2 when step=1, sampled on the same edge as en.
REQ-014 Priority per rising edge SHALL be: load, then en, then hold.
REQ-015 On load=1, q SHALL take d unchanged (no range check); wrap SHALL be 0 the following cycle.
REQ-016 With en=1, up, q<=limit: if q+inc<=limit then q<=q+inc, else q<=q+inc-(limit+1).
REQ-017 With en=1, down, q<=limit: if q>=inc then q<=q-inc, else q<=limit+1-(inc-q).
REQ-018 All range arithmetic SHALL use WIDTH+1 bits so limit = 2^WIDTH-1 wraps modulo 2^WIDTH without overflow.
REQ-019 With en=1 and q>limit (after load or a limit change), next q SHALL be 0 when counting up and limit when counting down, with wrap=1.
REQ-020 wrap SHALL be 1 for exactly the cycle after any edge where REQ-016/017 took the wrap-around branch or REQ-019 applied; otherwise 0.
REQ-021 limit=0 SHALL hold q at 0 and assert wrap on every enabled edge.
REQ-022 With en=0 and load=0, q SHALL hold and wrap SHALL be 0 the next cycle.
REQ-023 Changes to step, down or limit SHALL take effect on the next edge with no pipeline delay; latency input-to-q is one edge.

Reset
REQ-024 nrst=0 SHALL force q=0 and wrap=0 immediately, independent of clk.
REQ-025 While nrst=0 all other inputs SHALL be ignored; the first enabled edge after release counts from 0.
REQ-026 Reset asserted mid-count SHALL discard any pending load or wrap.

Configuration
REQ-027 Macro MODCNT_SAT_EN: when defined, port sat exists; with sat=1, an enabled step that would take the wrap-around branch SHALL instead clamp q to limit (up) or 0 (down) and set wrap=1 as a saturation-hit flag.
REQ-028 With sat=1, an already-clamped q SHALL stay clamped and wrap SHALL remain 1 on each further enabled edge in that direction.
REQ-029 Without MODCNT_SAT_EN, the sat port SHALL be absent and behaviour SHALL be pure modulo wrap per REQ-016..021.

Verification (WIDTH=4)
REQ-030 Up wrap: limit=9, load 8, then en=1, step=1, down=0 for one edge -> q=0, wrap=1 for one cycle.
REQ-031 Down wrap: limit=9, load 1, then en=1, step=1, down=1 -> q=9, wrap=1; next edge -> q=7, wrap=0.
REQ-032 Load priority and range recovery: limit=9, load=1, en=1, d=12 -> q=12, wrap=0; next edge en=1, up -> q=0, wrap=1.
REQ-033 Full range: limit=15, step=0, up, 16 edges from 0 -> q returns to 0, wrap high only after the 15->0 edge.
REQ-034 Async reset: nrst pulsed low between edges while q=6 -> q=0 and wrap=0 before the next clk edge.
REQ-035 Saturate (MODCNT_SAT_EN): limit=9, sat=1, load 8, en=1, step=1, up -> q=9, wrap=1; next edge -> q=9, wrap=1.
